// File: rtl/pattern_tx_pkg.sv
// pattern_tx_pkg: shared FSM encoding, default pattern and detector result macros
`ifndef PATTERN_TX_PKG_MACROS
`define PATTERN_TX_PKG_MACROS
`define FOUND 1'b1
`define NOTFOUND 1'b0
`endif

package pattern_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_GAP  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    localparam logic [3:0] DEF_PATTERN = 4'b1001;

endpackage

// File: rtl/pattern_tx.sv
// pattern_tx: sends reps copies of PATTERN MSB-first on x, with GAP zero bits between copies (ports: clk, reset active-low sync, start, reps in; x, valid, last_bit, busy, done registered out)
module pattern_tx
    import pattern_tx_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
    parameter int GAP = 1,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] reps,
    output logic             x,
    output logic             valid,
    output logic             last_bit,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(PAT_W);
    localparam logic [BW-1:0] TOP = BW'(PAT_W - 1);
    localparam logic [2:0] GAP_INIT = 3'(GAP > 0 ? GAP - 1 : 0);

    state_e state_q, state_d;
    logic [CNT_W-1:0] reps_q, reps_d, rep_q, rep_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [2:0] gap_q, gap_d;
    logic x_q, x_d, valid_q, valid_d, last_q, last_d, busy_q, busy_d, done_q, done_d;

    always_comb begin
        state_d = state_q;
        reps_d = reps_q;
        rep_d = rep_q;
        bit_d = bit_q;
        gap_d = gap_q;
        x_d = 1'b0;
        valid_d = 1'b0;
        last_d = 1'b0;
        busy_d = busy_q;
        done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && reps != '0) begin
                    state_d = ST_SEND;
                    reps_d = reps;
                    rep_d = CNT_W'(1);
                    bit_d = TOP;
                    x_d = PATTERN[PAT_W-1];
                    valid_d = 1'b1;
                    busy_d = 1'b1;
                end else if (start) begin
                    state_d = ST_DONE;
                    done_d = 1'b1;
                end
            end
            ST_SEND: begin
                if (bit_q != '0) begin
                    bit_d = bit_q - BW'(1);
                    x_d = PATTERN[bit_q - BW'(1)];
                    valid_d = 1'b1;
                    last_d = (bit_q == BW'(1));
                end else if (rep_q == reps_q) begin
                    state_d = ST_DONE;
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end else if (GAP > 0) begin
                    state_d = ST_GAP;
                    gap_d = GAP_INIT;
                    valid_d = 1'b1;
                end else begin
                    rep_d = rep_q + CNT_W'(1);
                    bit_d = TOP;
                    x_d = PATTERN[PAT_W-1];
                    valid_d = 1'b1;
                end
            end
            ST_GAP: begin
                valid_d = 1'b1;
                if (gap_q != '0) begin
                    gap_d = gap_q - 3'd1;
                end else begin
                    state_d = ST_SEND;
                    rep_d = rep_q + CNT_W'(1);
                    bit_d = TOP;
                    x_d = PATTERN[PAT_W-1];
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            reps_q <= '0;
            rep_q <= '0;
            bit_q <= '0;
            gap_q <= '0;
            x_q <= 1'b0;
            valid_q <= 1'b0;
            last_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            reps_q <= reps_d;
            rep_q <= rep_d;
            bit_q <= bit_d;
            gap_q <= gap_d;
            x_q <= x_d;
            valid_q <= valid_d;
            last_q <= last_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign x = x_q;
    assign valid = valid_q;
    assign last_bit = last_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_pattern_tx.sv
// tb_pattern_tx: directed checks of pattern_tx with GAP=1 and GAP=0 instances
module tb_pattern_tx;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start_a = 1'b0, start_b = 1'b0;
    logic [3:0] reps_a = '0, reps_b = '0;
    logic x_a, valid_a, last_a, busy_a, done_a;
    logic x_b, valid_b, last_b, busy_b, done_b;
    int errors = 0;
    int checks = 0;

    wire [4:0] obs_a = {x_a, valid_a, last_a, busy_a, done_a};
    wire [4:0] obs_b = {x_b, valid_b, last_b, busy_b, done_b};

    // scenario-1 expectations, cycle 1 at bit 9 down to cycle 10 at bit 0
    logic [9:0] e1_x = 10'b1001010010;
    logic [9:0] e1_v = 10'b1111111110;
    logic [9:0] e1_l = 10'b0001000010;
    logic [9:0] e1_b = 10'b1111111110;
    logic [9:0] e1_d = 10'b0000000001;

    pattern_tx #(.PAT_W(4), .PATTERN(4'b1001), .GAP(1), .CNT_W(4)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .reps(reps_a),
        .x(x_a), .valid(valid_a), .last_bit(last_a), .busy(busy_a), .done(done_a)
    );

    pattern_tx #(.PAT_W(4), .PATTERN(4'b1001), .GAP(0), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .reps(reps_b),
        .x(x_b), .valid(valid_b), .last_bit(last_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick;
        tick;
        checks++;
        if (obs_a !== 5'b0) begin
            errors++;
            $display("FAIL reset_a: got %b want 00000", obs_a);
        end
        checks++;
        if (obs_b !== 5'b0) begin
            errors++;
            $display("FAIL reset_b: got %b want 00000", obs_b);
        end
        reset = 1'b1;
        tick;
    endtask

    task automatic test_gap1;
        logic [4:0] exp;
        start_a = 1'b1;
        reps_a = 4'd2;
        tick;
        start_a = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            exp = {e1_x[10-i], e1_v[10-i], e1_l[10-i], e1_b[10-i], e1_d[10-i]};
            checks++;
            if (obs_a !== exp) begin
                errors++;
                $display("FAIL gap1_cycle%0d: got %b want %b", i, obs_a, exp);
            end
            tick;
        end
        checks++;
        if (obs_a !== 5'b0) begin
            errors++;
            $display("FAIL gap1_idle: got %b want 00000", obs_a);
        end
    endtask

    task automatic test_back_to_back;
        logic [11:0] ex = 12'b100110011001;
        logic [11:0] el = 12'b000100010001;
        logic [4:0] exp;
        start_b = 1'b1;
        reps_b = 4'd3;
        tick;
        start_b = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            exp = (i == 13) ? 5'b00001 : {ex[12-i], 1'b1, el[12-i], 1'b1, 1'b0};
            checks++;
            if (obs_b !== exp) begin
                errors++;
                $display("FAIL b2b_cycle%0d: got %b want %b", i, obs_b, exp);
            end
            tick;
        end
        checks++;
        if (obs_b !== 5'b0) begin
            errors++;
            $display("FAIL b2b_idle: got %b want 00000", obs_b);
        end
    endtask

    task automatic test_reps_zero;
        start_a = 1'b1;
        reps_a = 4'd0;
        tick;
        start_a = 1'b0;
        checks++;
        if (obs_a !== 5'b00001) begin
            errors++;
            $display("FAIL reps0_done: got %b want 00001", obs_a);
        end
        tick;
        checks++;
        if (obs_a !== 5'b0) begin
            errors++;
            $display("FAIL reps0_idle: got %b want 00000", obs_a);
        end
        tick;
        checks++;
        if (obs_a !== 5'b0) begin
            errors++;
            $display("FAIL reps0_stay: got %b want 00000", obs_a);
        end
    endtask

    task automatic test_mid_reset;
        logic [4:0] exp;
        start_a = 1'b1;
        reps_a = 4'd2;
        tick;
        start_a = 1'b0;
        tick;
        tick;
        checks++;
        if (obs_a !== 5'b01010) begin
            errors++;
            $display("FAIL midrst_bit3: got %b want 01010", obs_a);
        end
        reset = 1'b0;
        tick;
        checks++;
        if (obs_a !== 5'b0) begin
            errors++;
            $display("FAIL midrst_clear: got %b want 00000", obs_a);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if (obs_a !== 5'b0) begin
                errors++;
                $display("FAIL midrst_quiet%0d: got %b want 00000", i, obs_a);
            end
        end
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            exp = {e1_x[10-i], e1_v[10-i], e1_l[10-i], e1_b[10-i], e1_d[10-i]};
            checks++;
            if (obs_a !== exp) begin
                errors++;
                $display("FAIL midrst_restart%0d: got %b want %b", i, obs_a, exp);
            end
            tick;
        end
    endtask

    task automatic test_ignore_start;
        logic [4:0] exp;
        start_a = 1'b1;
        reps_a = 4'd2;
        tick;
        for (int i = 1; i <= 10; i++) begin
            start_a = (i == 2 || i == 3 || i == 6 || i == 10);
            reps_a = (i % 2 == 0) ? 4'd7 : 4'd0;
            exp = {e1_x[10-i], e1_v[10-i], e1_l[10-i], e1_b[10-i], e1_d[10-i]};
            checks++;
            if (obs_a !== exp) begin
                errors++;
                $display("FAIL ignore_cycle%0d: got %b want %b", i, obs_a, exp);
            end
            tick;
            start_a = 1'b0;
        end
        tick;
        checks++;
        if (obs_a !== 5'b0) begin
            errors++;
            $display("FAIL ignore_idle: got %b want 00000", obs_a);
        end
    endtask

    task automatic test_max_reps;
        int nv = 0, nl = 0, nd = 0, cyc = 0;
        start_a = 1'b1;
        reps_a = 4'd15;
        tick;
        start_a = 1'b0;
        while (nd == 0 && cyc < 200) begin
            nv += int'(valid_a);
            nl += int'(last_a);
            nd += int'(done_a);
            cyc++;
            tick;
        end
        for (int i = 0; i < 5; i++) begin
            nv += int'(valid_a);
            nd += int'(done_a);
            tick;
        end
        checks++;
        if (cyc >= 200) begin
            errors++;
            $display("FAIL max_timeout: got %0d cycles want done within 200", cyc);
        end
        checks++;
        if (nv != 74) begin
            errors++;
            $display("FAIL max_valid: got %0d want 74", nv);
        end
        checks++;
        if (nl != 15) begin
            errors++;
            $display("FAIL max_last: got %0d want 15", nl);
        end
        checks++;
        if (nd != 1) begin
            errors++;
            $display("FAIL max_done: got %0d want 1", nd);
        end
        checks++;
        if (cyc != 75) begin
            errors++;
            $display("FAIL max_done_cycle: got %0d want 75", cyc);
        end
    endtask

    initial begin
        test_reset;
        test_gap1;
        test_back_to_back;
        test_reps_zero;
        test_mid_reset;
        test_ignore_start;
        test_max_reps;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
